// File: rtl/symbol_draw_sequencer_if.sv
// Host and symbol-drawer signal bundle for the grid draw sequencer.
interface symbol_draw_sequencer_if;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;

  logic             start;
  logic [MASK_W-1:0] cell_mask;
  logic             sym_done;
  logic             sym_in;
  logic [X_W-1:0]   sym_x;
  logic [Y_W-1:0]   sym_y;
  logic             plot;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, cell_mask, sym_done,
    input  sym_in, sym_x, sym_y, plot, busy, done, error
  );

  modport slave (
    input  start, cell_mask, sym_done,
    output sym_in, sym_x, sym_y, plot, busy, done, error
  );
endinterface

// File: rtl/symbol_draw_sequencer.sv
// Walks a 4x4 grid of cells, enabling an external symbol drawer at each
// occupied cell's origin, with a per-cell draw timeout and sticky error.
module symbol_draw_sequencer #(
  parameter logic [7:0] X0      = 8'd48,
  parameter logic [6:0] Y0      = 7'd28,
  parameter logic [5:0] TIMEOUT = 6'd63
) (
  input  logic                   clk,
  input  logic                   reset_n,
  symbol_draw_sequencer_if.slave bus
);
  localparam int unsigned MASK_W = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MASK_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SCAN   = 3'd2,
    DRAW   = 3'd3,
    GAP    = 3'd4,
    NEXT   = 3'd5,
    FINISH = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              sym_in_q, plot_q, busy_q, done_q;

  // Cell origin: column/row index scaled by the 16-pixel cell pitch, wrapping.
  function automatic logic [X_W-1:0] cell_x(input logic [IDX_W-1:0] i);
    return X0 + {2'b00, i[1:0], 4'b0000};
  endfunction

  function automatic logic [Y_W-1:0] cell_y(input logic [IDX_W-1:0] i);
    return Y0 + {1'b0, i[3:2], 4'b0000};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      x_q      <= X0;
      y_q      <= Y0;
      sym_in_q <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sym_in_q <= (state_d == DRAW);
      plot_q   <= (state_q == DRAW);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == FINISH);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: begin
        mask_d  = bus.cell_mask;
        idx_d   = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        x_d     = cell_x('0);
        y_d     = cell_y('0);
        state_d = SCAN;
      end
      SCAN: state_d = mask_q[idx_q] ? DRAW : NEXT;
      // A completion in the timeout cycle still counts as a clean finish.
      DRAW: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (bus.sym_done) begin
          state_d = GAP;
        end else if (cnt_d == TIMEOUT) begin
          err_d   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d   = IDX_W'(idx_q + 1'b1);
          x_d     = cell_x(IDX_W'(idx_q + 1'b1));
          y_d     = cell_y(IDX_W'(idx_q + 1'b1));
          state_d = SCAN;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.sym_in = sym_in_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = err_q;
  assign bus.sym_x  = x_q;
  assign bus.sym_y  = y_q;
endmodule

// File: tb/tb_symbol_draw_sequencer.sv
// Bench for symbol_draw_sequencer: directed vector table, reset abort,
// and randomized grid passes scored against a pass-level reference model.
module tb_symbol_draw_sequencer;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  symbol_draw_sequencer_if bus ();
  symbol_draw_sequencer_if bus2 ();

  symbol_draw_sequencer #(.X0(8'd48), .Y0(7'd28), .TIMEOUT(6'd63)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  symbol_draw_sequencer #(.X0(8'd250), .Y0(7'd28), .TIMEOUT(6'd63)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    int         len;
  } burst_t;

  typedef struct {
    logic [15:0] mask;
    int          lat;
    int          e_rel;
    int          e_bursts;
    int          e_cycles;
    bit          e_err;
    int          e_lx;
    int          e_ly;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // Drawer model: raises sym_done once it has seen lat_arr[k]+1 enabled cycles.
  int   lat_arr [16];
  int   dcnt   = 0;
  int   dburst = 0;
  int   dbase  = 0;
  logic d_prev = 1'b0;
  logic spur   = 1'b0;
  logic drawer_done;

  always @(posedge clk) begin
    if (d_prev && !bus.sym_in) dburst <= dburst + 1;
    d_prev <= bus.sym_in;
    dcnt   <= bus.sym_in ? dcnt + 1 : 0;
  end

  always_comb drawer_done = bus.sym_in && (dcnt == lat_arr[4'(dburst - dbase)]);
  assign bus.sym_done   = drawer_done | (spur & ~bus.sym_in);
  assign bus2.start     = bus.start;
  assign bus2.cell_mask = bus.cell_mask;
  assign bus2.sym_done  = bus.sym_done;

  // Monitor: collects bursts, done timing and per-cycle rule violations.
  logic       mon_en = 1'b0;
  logic       prev_sym_in = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] bx = '0;
  logic [6:0] by = '0;
  int         blen = 0;
  int         rel = 0;
  int         done_cnt = 0;
  int         done_rel = -1;
  logic       err_at_done = 1'b0;
  int         plot_bad = 0, sym_bad = 0, stab_bad = 0, wrap_bad = 0, wrap_seen = 0;
  burst_t     obs_q[$];
  burst_t     exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy && !prev_busy) rel = 0;
      else rel++;
      if (bus.plot !== prev_sym_in) plot_bad++;
      if (bus.sym_in && !bus.busy) sym_bad++;
      if (bus2.sym_in !== bus.sym_in) wrap_bad++;
      if (bus.sym_in) begin
        if (!prev_sym_in) begin
          bx   = bus.sym_x;
          by   = bus.sym_y;
          blen = 0;
        end else if (bus.sym_x !== bx || bus.sym_y !== by) begin
          stab_bad++;
        end
        blen++;
        if (bus.sym_x == 8'd64) begin
          if (bus2.sym_x === 8'd10) wrap_seen++;
          else wrap_bad++;
        end
      end else if (prev_sym_in) begin
        obs_q.push_back('{bx, by, blen});
      end
      if (bus.done) begin
        done_cnt++;
        done_rel    = rel;
        err_at_done = bus.error;
      end
    end
    prev_sym_in = bus.sym_in;
    prev_busy   = bus.busy;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: one pass costs LOAD plus SCAN/NEXT per cell, plus draw+gap per set cell.
  task automatic model(input logic [15:0] m, output int e_rel, output bit e_err);
    int     k;
    burst_t b;
    exp_q.delete();
    e_rel = 1;
    e_err = 1'b0;
    k     = 0;
    for (int i = 0; i < 16; i++) begin
      e_rel += 2;
      if (m[i]) begin
        b.len = (lat_arr[k] + 1 < 63) ? lat_arr[k] + 1 : 63;
        if (lat_arr[k] + 1 > 63) e_err = 1'b1;
        b.x = 8'((48 + 16 * (i % 4)) % 256);
        b.y = 7'((28 + 16 * (i / 4)) % 128);
        exp_q.push_back(b);
        e_rel += b.len + 1;
        k++;
      end
    end
  endtask

  task automatic run_pass(input logic [15:0] m, input bit rnd,
                          output int o_nb, output int o_cyc, output int o_rel,
                          output bit o_err, output int o_lx, output int o_ly);
    int e_rel, d0, ob, pb, sb, sbb, wb, budget;
    bit e_err;
    model(m, e_rel, e_err);
    d0 = done_cnt; ob = obs_q.size();
    pb = plot_bad; sb = sym_bad; sbb = stab_bad; wb = wrap_bad;
    dbase = dburst;
    bus.cell_mask = m;
    bus.start     = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk); #1;
    chk("busy_in_pass", 32'(bus.busy), 1);
    chk("error_cleared_by_load", 32'(bus.error), 0);
    budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      bus.cell_mask = rnd ? 16'($urandom) : ~m;
      if (rnd) begin
        spur      = 1'($urandom);
        bus.start = (bus.busy && !bus.done) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk); #1;
      budget++;
    end
    bus.start = 1'b0;
    spur      = 1'b0;
    chk("done_pulse_seen", done_cnt - d0, 1);
    chk("done_latency", done_rel, e_rel);
    chk("error_at_finish", 32'(err_at_done), 32'(e_err));
    repeat (2) begin @(negedge clk); #1; end
    chk("done_no_repeat", done_cnt - d0, 1);
    chk("idle_not_busy", 32'(bus.busy), 0);
    chk("error_held_in_idle", 32'(bus.error), 32'(e_err));
    chk("burst_count", obs_q.size() - ob, exp_q.size());
    for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
      chk($sformatf("burst%0d_x", i), 32'(obs_q[ob+i].x), 32'(exp_q[i].x));
      chk($sformatf("burst%0d_y", i), 32'(obs_q[ob+i].y), 32'(exp_q[i].y));
      chk($sformatf("burst%0d_len", i), obs_q[ob+i].len, exp_q[i].len);
    end
    chk("plot_follows_sym_in", plot_bad - pb, 0);
    chk("sym_in_only_when_busy", sym_bad - sb, 0);
    chk("xy_stable_in_draw", stab_bad - sbb, 0);
    chk("wrap_instance_sync", wrap_bad - wb, 0);
    o_nb  = obs_q.size() - ob;
    o_cyc = 0;
    for (int i = ob; i < obs_q.size(); i++) o_cyc += obs_q[i].len;
    o_rel = done_rel;
    o_err = err_at_done;
    o_lx  = (o_nb > 0) ? 32'(obs_q[obs_q.size()-1].x) : -1;
    o_ly  = (o_nb > 0) ? 32'(obs_q[obs_q.size()-1].y) : -1;
  endtask

  initial begin
    vec_t vecs [6];
    int   nb, cyc, rl, lx, ly, d0, budget;
    bit   er;

    vecs[0] = '{16'h0000,    5,  33,  0,   0, 1'b0,  0,  0};
    vecs[1] = '{16'h0020,   50,  85,  1,  51, 1'b0, 64, 44};
    vecs[2] = '{16'hFFFF,    3, 113, 16,  64, 1'b0, 96, 76};
    vecs[3] = '{16'h0001, 1000,  97,  1,  63, 1'b1, 48, 28};
    vecs[4] = '{16'h8001,   62, 161,  2, 126, 1'b0, 96, 76};
    vecs[5] = '{16'h0001,   63,  97,  1,  63, 1'b1, 48, 28};

    bus.start     = 1'b0;
    bus.cell_mask = '0;
    foreach (lat_arr[i]) lat_arr[i] = 5;

    reset_n = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    chk("rst_sym_in", 32'(bus.sym_in), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_error", 32'(bus.error), 0);
    chk("rst_sym_x", 32'(bus.sym_x), 48);
    chk("rst_sym_y", 32'(bus.sym_y), 28);
    chk("rst_wrap_sym_x", 32'(bus2.sym_x), 250);
    reset_n = 1'b1;
    @(negedge clk); #1;
    mon_en = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    chk("idle_without_start", 32'(bus.busy), 0);

    for (int t = 0; t < 6; t++) begin
      foreach (lat_arr[i]) lat_arr[i] = vecs[t].lat;
      run_pass(vecs[t].mask, 1'b0, nb, cyc, rl, er, lx, ly);
      chk($sformatf("vec%0d_bursts", t), nb, vecs[t].e_bursts);
      chk($sformatf("vec%0d_sym_in_cycles", t), cyc, vecs[t].e_cycles);
      chk($sformatf("vec%0d_done_latency", t), rl, vecs[t].e_rel);
      chk($sformatf("vec%0d_error", t), 32'(er), 32'(vecs[t].e_err));
      if (vecs[t].e_bursts > 0) begin
        chk($sformatf("vec%0d_last_x", t), lx, vecs[t].e_lx);
        chk($sformatf("vec%0d_last_y", t), ly, vecs[t].e_ly);
      end
    end

    // Abort in the middle of cell 3's draw, then restart from cell 0.
    foreach (lat_arr[i]) lat_arr[i] = 10;
    dbase = dburst;
    d0    = done_cnt;
    bus.cell_mask = 16'hFFFF;
    bus.start     = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    budget = 0;
    while (!((dburst - dbase == 3) && bus.sym_in) && budget < 500) begin
      @(negedge clk); #1;
      budget++;
    end
    chk("abort_reached_cell3", 32'(bus.sym_in), 1);
    chk("abort_cell3_x", 32'(bus.sym_x), 96);
    chk("abort_cell3_y", 32'(bus.sym_y), 28);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_async_sym_in", 32'(bus.sym_in), 0);
    chk("abort_async_plot", 32'(bus.plot), 0);
    chk("abort_async_busy", 32'(bus.busy), 0);
    chk("abort_async_error", 32'(bus.error), 0);
    chk("abort_async_sym_x", 32'(bus.sym_x), 48);
    chk("abort_async_sym_y", 32'(bus.sym_y), 28);
    repeat (3) begin @(negedge clk); #1; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", 32'(bus.busy), 0);
    mon_en = 1'b1;
    @(negedge clk); #1;
    lat_arr[0] = 7;
    lat_arr[1] = 4;
    run_pass(16'h0009, 1'b0, nb, cyc, rl, er, lx, ly);
    chk("restart_bursts", nb, 2);
    chk("restart_sym_in_cycles", cyc, 13);

    for (int r = 0; r < 20; r++) begin
      foreach (lat_arr[i])
        lat_arr[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(58, 80))
                                                 : int'($urandom_range(0, 12));
      run_pass(16'($urandom), 1'b1, nb, cyc, rl, er, lx, ly);
    end

    chk("wrap_col1_seen", 32'(wrap_seen > 0), 1);
    chk("wrap_col1_value", wrap_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
